// File: rtl/mesi_isc_broad_req_arb.sv
// Round-robin arbiter that funnels four CPU broadcast requests into the single
// broadcast-FIFO write port, tagging each push with a wrapping broadcast ID.
module mesi_isc_broad_req_arb #(
  parameter int ADDR_WIDTH               = 32,
  parameter int BROAD_TYPE_WIDTH         = 2,
  parameter int BROAD_ID_WIDTH           = 5,
  parameter int BROAD_REQ_FIFO_SIZE      = 4,
  parameter int BROAD_REQ_FIFO_SIZE_LOG2 = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [3:0]                            req_array_i,
  input  logic [4*ADDR_WIDTH-1:0]               addr_array_i,
  input  logic [4*BROAD_TYPE_WIDTH-1:0]         type_array_i,
  input  logic                                  broad_fifo_rd_i,
  input  logic                                  fifo_status_full_i,
  output logic [3:0]                            ack_array_o,
  output logic                                  broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0]                 broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]           broad_type_o,
  output logic [1:0]                            broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]             broad_id_o,
  output logic [BROAD_REQ_FIFO_SIZE_LOG2:0]     occupancy_o,
  output logic                                  underflow_o
);

  localparam int OCC_W = BROAD_REQ_FIFO_SIZE_LOG2 + 1;

  logic [3:0]                eligible_p0;
  logic                      pop_ok_p0;
  logic                      underflow_hit_p0;
  logic [OCC_W:0]            occ_eff_p0;
  logic                      grant_p0;
  logic [1:0]                winner_p0;
  logic [1:0]                last_grant;
  logic [BROAD_ID_WIDTH-1:0] id_cnt;

  // First eligible requester after the last winner, wrapping through all four.
  function automatic logic [1:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && elig[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Stage p0: eligibility, credit check and winner selection
  always_comb begin
    eligible_p0      = req_array_i & ~ack_array_o;
    pop_ok_p0        = broad_fifo_rd_i & ((occupancy_o != '0) | broad_fifo_wr_o);
    underflow_hit_p0 = broad_fifo_rd_i & (occupancy_o == '0) & ~broad_fifo_wr_o;
    occ_eff_p0       = {1'b0, occupancy_o} + (OCC_W+1)'(broad_fifo_wr_o)
                       - (OCC_W+1)'(pop_ok_p0);
    grant_p0         = (eligible_p0 != 4'b0000)
                       && (occ_eff_p0 < (OCC_W+1)'(BROAD_REQ_FIFO_SIZE))
                       && !(fifo_status_full_i && !broad_fifo_rd_i);
    winner_p0        = rr_pick(eligible_p0, last_grant);
  end

  // Stage p1: registered push, ack and credit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_array_o     <= '0;
      broad_fifo_wr_o <= 1'b0;
      broad_addr_o    <= '0;
      broad_type_o    <= '0;
      broad_cpu_id_o  <= '0;
      broad_id_o      <= '0;
      occupancy_o     <= '0;
      underflow_o     <= 1'b0;
      id_cnt          <= '0;
      last_grant      <= 2'd3;
    end else begin
      broad_fifo_wr_o <= grant_p0;
      ack_array_o     <= grant_p0 ? (4'b0001 << winner_p0) : 4'b0000;
      if (grant_p0) begin
        broad_addr_o   <= addr_array_i[int'(winner_p0)*ADDR_WIDTH +: ADDR_WIDTH];
        broad_type_o   <= type_array_i[int'(winner_p0)*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
        broad_cpu_id_o <= winner_p0;
        broad_id_o     <= id_cnt;
        id_cnt         <= id_cnt + 1'b1;
        last_grant     <= winner_p0;
      end
      occupancy_o <= occ_eff_p0[OCC_W-1:0];
      if (underflow_hit_p0) begin
        underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mesi_isc_broad_req_arb.sv
// Randomised scoreboard bench for the broadcast request arbiter: a cycle-level
// reference model predicts each edge's outputs and a negedge monitor compares.
module tb_mesi_isc_broad_req_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_array_i;
  logic [127:0] addr_array_i;
  logic [7:0]   type_array_i;
  logic         broad_fifo_rd_i;
  logic         fifo_status_full_i;
  logic [3:0]   ack_array_o;
  logic         broad_fifo_wr_o;
  logic [31:0]  broad_addr_o;
  logic [1:0]   broad_type_o;
  logic [1:0]   broad_cpu_id_o;
  logic [4:0]   broad_id_o;
  logic [2:0]   occupancy_o;
  logic         underflow_o;

  mesi_isc_broad_req_arb dut (
    .clk                (clk),
    .rst                (rst),
    .req_array_i        (req_array_i),
    .addr_array_i       (addr_array_i),
    .type_array_i       (type_array_i),
    .broad_fifo_rd_i    (broad_fifo_rd_i),
    .fifo_status_full_i (fifo_status_full_i),
    .ack_array_o        (ack_array_o),
    .broad_fifo_wr_o    (broad_fifo_wr_o),
    .broad_addr_o       (broad_addr_o),
    .broad_type_o       (broad_type_o),
    .broad_cpu_id_o     (broad_cpu_id_o),
    .broad_id_o         (broad_id_o),
    .occupancy_o        (occupancy_o),
    .underflow_o        (underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  ack;
    int          occ;
    logic        uf;
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [1:0]  cpu;
    logic [4:0]  id;
  } stat_t;

  typedef struct {
    logic [1:0]  cpu;
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [4:0]  id;
  } txn_t;

  stat_t stat_q[$];
  txn_t  txn_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference state: what the DUT outputs should currently show.
  logic [31:0] a_addr [4];
  logic [1:0]  a_type [4];
  int          m_occ, m_last, m_id;
  logic        m_wr, m_uf;
  logic [3:0]  m_ack, m_ack_prev;
  logic [31:0] m_addr;
  logic [1:0]  m_typ, m_cpu;
  logic [4:0]  m_bid;
  int          grants = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict the next edge, queue expectations.
  task automatic step(input logic rstn, input logic [3:0] req, input logic rdv, input logic fullv);
    stat_t      s;
    txn_t       t;
    logic       g;
    int         c, occ_eff;
    logic       pop;
    logic [3:0] elig;
    rst = rstn; req_array_i = req; broad_fifo_rd_i = rdv; fifo_status_full_i = fullv;
    for (int k = 0; k < 4; k++) begin
      addr_array_i[k*32 +: 32] = a_addr[k];
      type_array_i[k*2 +: 2]   = a_type[k];
    end
    g = 1'b0; c = 0;
    m_ack_prev = m_ack;
    if (!rstn) begin
      m_occ = 0; m_wr = 0; m_uf = 0; m_ack = 0; m_last = 3; m_id = 0;
      m_addr = 0; m_typ = 0; m_cpu = 0; m_bid = 0;
    end else begin
      elig    = req & ~m_ack;
      pop     = rdv && (m_occ > 0 || m_wr);
      occ_eff = m_occ + int'(m_wr) - int'(pop);
      if (rdv && m_occ == 0 && !m_wr) m_uf = 1'b1;
      if (elig != 0 && occ_eff < 4 && !(fullv && !rdv)) begin
        for (int k = 1; k <= 4; k++) begin
          if (!g && elig[(m_last + k) % 4]) begin
            g = 1'b1;
            c = (m_last + k) % 4;
          end
        end
      end
      m_occ = occ_eff;
      m_wr  = g;
      m_ack = g ? 4'(1 << c) : 4'b0000;
      if (g) begin
        m_addr = a_addr[c]; m_typ = a_type[c]; m_cpu = 2'(c); m_bid = 5'(m_id);
        m_id   = (m_id + 1) % 32;
        m_last = c;
        grants++;
      end
    end
    s = '{wr: m_wr, ack: m_ack, occ: m_occ, uf: m_uf, addr: m_addr, typ: m_typ, cpu: m_cpu, id: m_bid};
    t = '{cpu: m_cpu, addr: m_addr, typ: m_typ, id: m_bid};
    @(posedge clk);
    stat_q.push_back(s);
    if (g) txn_q.push_back(t);
    #1;
  endtask

  // Monitor: per-cycle status checks plus a pop of the transaction queue on each push.
  always @(negedge clk) begin
    stat_t s;
    txn_t  t;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("wr", 64'(broad_fifo_wr_o), 64'(s.wr));
      chk("ack", 64'(ack_array_o), 64'(s.ack));
      chk("occupancy", 64'(occupancy_o), 64'(s.occ));
      chk("underflow", 64'(underflow_o), 64'(s.uf));
      if (!s.wr) begin
        chk("hold_addr", 64'(broad_addr_o), 64'(s.addr));
        chk("hold_id", 64'(broad_id_o), 64'(s.id));
      end
      if (broad_fifo_wr_o === 1'b1) begin
        if (txn_q.size() == 0) begin
          chk("unexpected_push", 64'(broad_fifo_wr_o), 64'(0));
        end else begin
          t = txn_q.pop_front();
          chk("cpu_id", 64'(broad_cpu_id_o), 64'(t.cpu));
          chk("bid", 64'(broad_id_o), 64'(t.id));
          chk("addr", 64'(broad_addr_o), 64'(t.addr));
          chk("type", 64'(broad_type_o), 64'(t.typ));
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic       rdv, fullv;
    for (int k = 0; k < 4; k++) begin
      a_addr[k] = 32'h100 * (k + 1);
      a_type[k] = 2'(k);
    end
    m_ack = 0; m_occ = 0; m_wr = 0; m_uf = 0; m_last = 3; m_id = 0;
    m_addr = 0; m_typ = 0; m_cpu = 0; m_bid = 0;
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    // Single request from CPU0
    a_addr[0] = 32'h1000; a_type[0] = 2'd2;
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);

    // All four held, no pops, then one pop frees exactly one slot
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 4'b0000, 1'b1, 1'b0);

    // Fairness after CPU2 wins
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0101, 1'b0, 1'b0);

    // ID wrap with continuous traffic, then reset while requests are pending
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 4'b1111, 1'b1, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);

    // Randomised requesters following the hold-until-ack protocol
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (m_ack_prev[k]) rq[k] = 1'b0;
        if (!rq[k] && $urandom_range(0, 2) == 0) begin
          rq[k]     = 1'b1;
          a_addr[k] = $urandom();
          a_type[k] = 2'($urandom_range(0, 3));
        end
      end
      rdv   = ($urandom_range(0, 2) == 0);
      fullv = (m_occ == 4) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, rq, rdv, fullv);
        rq = 4'b0000;
      end else begin
        step(1'b1, rq, rdv, fullv);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("stat_queue_drained", 64'(stat_q.size()), 64'(0));
    chk("txn_queue_drained", 64'(txn_q.size()), 64'(0));
    chk("enough_grants", 64'(grants > 100), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
